// File: rtl/pipe_hazard_ctrl.sv
// In-flight instruction chain from decode to writeback: RAW hazard detection,
// writeback bypass selection, branch squash and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int            IW       = 8,
    parameter int            RW       = 2,
    parameter int            STAGES   = 4,
    parameter int            BR_STAGE = 3,
    parameter int            FWD      = 1,
    parameter int            CW       = 16,
    parameter logic [IW-1:0] NOP      = 8'b00001010
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [IW-1:0]        fetch_instr,
    input  logic                 fetch_wr,
    input  logic [RW-1:0]        fetch_dst,
    input  logic                 fetch_use1,
    input  logic                 fetch_use2,
    input  logic [RW-1:0]        fetch_src1,
    input  logic [RW-1:0]        fetch_src2,
    output logic                 fetch_ready,
    input  logic                 flush,
    input  logic                 count_en,
    input  logic                 count_clr,
    output logic [STAGES*IW-1:0] stage_instr,
    output logic [STAGES-1:0]    stage_valid,
    output logic                 stall,
    output logic                 fwd_sel1,
    output logic                 fwd_sel2,
    output logic                 rf_write,
    output logic [RW-1:0]        rf_waddr,
    output logic [CW-1:0]        cycle_cnt,
    output logic [CW-1:0]        stall_cnt,
    output logic [CW-1:0]        flush_cnt,
    output logic [CW-1:0]        retire_cnt
);

    localparam bit FWD_EN = (FWD != 0);

    logic [STAGES:1] valid_q;
    logic [STAGES:1] wr_q;
    logic [IW-1:0]   instr_q [1:STAGES];
    logic [RW-1:0]   dst_q   [1:STAGES];

    // Source fields are only consulted while the instruction sits in decode,
    // so they are not carried down the chain.
    logic            use1_q;
    logic            use2_q;
    logic [RW-1:0]   src1_q;
    logic [RW-1:0]   src2_q;

    logic mid_hit1;
    logic mid_hit2;
    logic wb_hit1;
    logic wb_hit2;
    logic need1;
    logic need2;
    logic stall1;
    logic stall2;
    logic hold;

    always_comb begin
        mid_hit1 = 1'b0;
        mid_hit2 = 1'b0;
        wb_hit1  = 1'b0;
        wb_hit2  = 1'b0;
        for (int j = 2; j <= STAGES; j++) begin
            if (valid_q[j] && wr_q[j]) begin
                if (dst_q[j] == src1_q) begin
                    if (j == STAGES) wb_hit1  = 1'b1;
                    else             mid_hit1 = 1'b1;
                end
                if (dst_q[j] == src2_q) begin
                    if (j == STAGES) wb_hit2  = 1'b1;
                    else             mid_hit2 = 1'b1;
                end
            end
        end
    end

    assign need1  = valid_q[1] && use1_q;
    assign need2  = valid_q[1] && use2_q;
    // A writeback-stage match only stalls when the bypass is not built in.
    assign stall1 = need1 && (mid_hit1 || (wb_hit1 && !FWD_EN));
    assign stall2 = need2 && (mid_hit2 || (wb_hit2 && !FWD_EN));
    assign stall  = stall1 || stall2;

    assign fwd_sel1 = FWD_EN && need1 && wb_hit1 && !stall;
    assign fwd_sel2 = FWD_EN && need2 && wb_hit2 && !stall;

    assign hold        = stall && !flush;
    assign fetch_ready = !stall && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            wr_q    <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                instr_q[k] <= NOP;
                dst_q[k]   <= '0;
            end
            use1_q <= 1'b0;
            use2_q <= 1'b0;
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            for (int k = 2; k <= STAGES; k++) begin
                if ((flush && k < BR_STAGE) || (hold && k == 2)) begin
                    valid_q[k] <= 1'b0;
                    wr_q[k]    <= 1'b0;
                    instr_q[k] <= NOP;
                    dst_q[k]   <= '0;
                end else begin
                    valid_q[k] <= valid_q[k-1];
                    wr_q[k]    <= wr_q[k-1];
                    instr_q[k] <= instr_q[k-1];
                    dst_q[k]   <= dst_q[k-1];
                end
            end

            if (flush || (!hold && !fetch_valid)) begin
                valid_q[1] <= 1'b0;
                wr_q[1]    <= 1'b0;
                instr_q[1] <= NOP;
                dst_q[1]   <= '0;
                use1_q     <= 1'b0;
                use2_q     <= 1'b0;
                src1_q     <= '0;
                src2_q     <= '0;
            end else if (!hold) begin
                valid_q[1] <= 1'b1;
                wr_q[1]    <= fetch_wr;
                instr_q[1] <= fetch_instr;
                dst_q[1]   <= fetch_dst;
                use1_q     <= fetch_use1;
                use2_q     <= fetch_use2;
                src1_q     <= fetch_src1;
                src2_q     <= fetch_src2;
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic inc);
        if (inc && (cnt != {CW{1'b1}})) return cnt + CW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || count_clr) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (count_en) begin
            cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
            stall_cnt  <= sat_inc(stall_cnt, hold);
            flush_cnt  <= sat_inc(flush_cnt, flush);
            retire_cnt <= sat_inc(retire_cnt, valid_q[STAGES]);
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage_out
        assign stage_instr[k*IW-1 -: IW] = instr_q[k];
        assign stage_valid[k-1]          = valid_q[k];
    end

    assign rf_write = valid_q[STAGES] && wr_q[STAGES];
    assign rf_waddr = dst_q[STAGES];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three instances (forwarding, stall-only,
// 4-bit counters) share one stimulus stream; each task checks one scenario.
module tb_pipe_hazard_ctrl;

    localparam int ST = 4;
    localparam logic [7:0] NOP = 8'b00001010;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_valid = 1'b0;
    logic [7:0] fetch_instr = NOP;
    logic       fetch_wr = 1'b0;
    logic [1:0] fetch_dst = 2'd0;
    logic       fetch_use1 = 1'b0;
    logic       fetch_use2 = 1'b0;
    logic [1:0] fetch_src1 = 2'd0;
    logic [1:0] fetch_src2 = 2'd0;
    logic       flush = 1'b0;
    logic       count_en = 1'b0;
    logic       count_clr = 1'b0;

    logic        a_ready, a_stall, a_fwd1, a_fwd2, a_rf_write;
    logic [31:0] a_instr;
    logic [3:0]  a_valid;
    logic [1:0]  a_waddr;
    logic [15:0] a_cyc_cnt, a_stall_cnt, a_flush_cnt, a_retire_cnt;

    logic        n_ready, n_stall, n_fwd1, n_fwd2, n_rf_write;
    logic [31:0] n_instr;
    logic [3:0]  n_valid;
    logic [1:0]  n_waddr;
    logic [15:0] n_cyc_cnt, n_stall_cnt, n_flush_cnt, n_retire_cnt;

    logic        c_ready, c_stall, c_fwd1, c_fwd2, c_rf_write;
    logic [31:0] c_instr;
    logic [3:0]  c_valid;
    logic [1:0]  c_waddr;
    logic [3:0]  c_cyc_cnt, c_stall_cnt, c_flush_cnt, c_retire_cnt;

    pipe_hazard_ctrl #(.FWD(1)) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_wr(fetch_wr), .fetch_dst(fetch_dst), .fetch_use1(fetch_use1), .fetch_use2(fetch_use2),
        .fetch_src1(fetch_src1), .fetch_src2(fetch_src2), .fetch_ready(a_ready), .flush(flush),
        .count_en(count_en), .count_clr(count_clr), .stage_instr(a_instr), .stage_valid(a_valid),
        .stall(a_stall), .fwd_sel1(a_fwd1), .fwd_sel2(a_fwd2), .rf_write(a_rf_write),
        .rf_waddr(a_waddr), .cycle_cnt(a_cyc_cnt), .stall_cnt(a_stall_cnt),
        .flush_cnt(a_flush_cnt), .retire_cnt(a_retire_cnt)
    );

    pipe_hazard_ctrl #(.FWD(0)) dut_nf (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_wr(fetch_wr), .fetch_dst(fetch_dst), .fetch_use1(fetch_use1), .fetch_use2(fetch_use2),
        .fetch_src1(fetch_src1), .fetch_src2(fetch_src2), .fetch_ready(n_ready), .flush(flush),
        .count_en(count_en), .count_clr(count_clr), .stage_instr(n_instr), .stage_valid(n_valid),
        .stall(n_stall), .fwd_sel1(n_fwd1), .fwd_sel2(n_fwd2), .rf_write(n_rf_write),
        .rf_waddr(n_waddr), .cycle_cnt(n_cyc_cnt), .stall_cnt(n_stall_cnt),
        .flush_cnt(n_flush_cnt), .retire_cnt(n_retire_cnt)
    );

    pipe_hazard_ctrl #(.CW(4)) dut_c4 (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_wr(fetch_wr), .fetch_dst(fetch_dst), .fetch_use1(fetch_use1), .fetch_use2(fetch_use2),
        .fetch_src1(fetch_src1), .fetch_src2(fetch_src2), .fetch_ready(c_ready), .flush(flush),
        .count_en(count_en), .count_clr(count_clr), .stage_instr(c_instr), .stage_valid(c_valid),
        .stall(c_stall), .fwd_sel1(c_fwd1), .fwd_sel2(c_fwd2), .rf_write(c_rf_write),
        .rf_waddr(c_waddr), .cycle_cnt(c_cyc_cnt), .stall_cnt(c_stall_cnt),
        .flush_cnt(c_flush_cnt), .retire_cnt(c_retire_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] dst;
        int         due;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic offer(input logic v, input logic [7:0] ins, input logic wr, input logic [1:0] dst,
                         input logic u1, input logic [1:0] s1, input logic u2, input logic [1:0] s2);
        fetch_valid = v;
        fetch_instr = ins;
        fetch_wr    = wr;
        fetch_dst   = dst;
        fetch_use1  = u1;
        fetch_src1  = s1;
        fetch_use2  = u2;
        fetch_src2  = s2;
    endtask

    task automatic idle();
        offer(1'b0, NOP, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        flush = 1'b0;
        count_en = 1'b0;
        count_clr = 1'b0;
        idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (a_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_valid: got %b want 0000", a_valid); end
        n_checks++; if (a_instr !== {4{NOP}}) begin n_errors++; $display("FAIL reset_instr: got %h want %h", a_instr, {4{NOP}}); end
        n_checks++; if ({a_stall, a_fwd1, a_fwd2} !== 3'b000) begin n_errors++; $display("FAIL reset_hazard: got %b want 000", {a_stall, a_fwd1, a_fwd2}); end
        n_checks++; if ({a_rf_write, a_waddr} !== 3'b000) begin n_errors++; $display("FAIL reset_rf: got %b want 000", {a_rf_write, a_waddr}); end
        n_checks++; if ({a_cyc_cnt, a_stall_cnt, a_flush_cnt, a_retire_cnt} !== 64'd0) begin n_errors++; $display("FAIL reset_counters: got %h want 0", {a_cyc_cnt, a_stall_cnt, a_flush_cnt, a_retire_cnt}); end
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        flush = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_flush: got %b want 0", a_ready); end
        flush = 1'b0;
        @(negedge clock);
        #1;
        n_checks++; if (a_cyc_cnt !== 16'd0) begin n_errors++; $display("FAIL count_en_off: cycle_cnt got %0d want 0", a_cyc_cnt); end
    endtask

    task automatic test_independent();
        int  stalls = 0;
        wb_t e;
        do_reset();
        count_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i < 3) offer(1'b1, 8'(8'h40 + i), 1'b1, 2'(i + 1), 1'b0, 2'd0, 1'b0, 2'd0);
            else       idle();
            #1;
            if (i < 3) begin
                n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL indep_ready i=%0d: got %b want 1", i, a_ready); end
                sb_q.push_back('{dst: 2'(i + 1), due: cyc + ST});
            end
            if (a_stall) stalls++;
            if (a_rf_write) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL indep_wb cyc=%0d: got write r%0d want none", cyc, a_waddr);
                end else begin
                    e = sb_q.pop_front();
                    if (a_waddr !== e.dst || cyc != e.due) begin
                        n_errors++; $display("FAIL indep_wb: got r%0d at %0d want r%0d at %0d", a_waddr, cyc, e.dst, e.due);
                    end
                end
            end
        end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL indep_pending: got %0d writes missing want 0", sb_q.size()); end
        n_checks++; if (stalls != 0) begin n_errors++; $display("FAIL indep_stall: got %0d stall cycles want 0", stalls); end
        n_checks++; if (a_retire_cnt !== 16'd3) begin n_errors++; $display("FAIL indep_retire: got %0d want 3", a_retire_cnt); end
    endtask

    // A writes r1, B reads r1 on the very next fetch.
    task automatic test_raw(input bit nf);
        int          n_stall_exp = nf ? 3 : 2;
        logic        st, f1, f2, rw, rdy, exp_st, exp_f1;
        logic [1:0]  wa;
        logic [15:0] scnt;
        wb_t         e;
        do_reset();
        count_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 0)      offer(1'b1, 8'hA1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
            else if (i == 1) offer(1'b1, 8'hB2, 1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0);
            else             idle();
            #1;
            st  = nf ? n_stall    : a_stall;
            f1  = nf ? n_fwd1     : a_fwd1;
            f2  = nf ? n_fwd2     : a_fwd2;
            rw  = nf ? n_rf_write : a_rf_write;
            wa  = nf ? n_waddr    : a_waddr;
            rdy = nf ? n_ready    : a_ready;
            if (i < 2) begin
                n_checks++; if (rdy !== 1'b1) begin n_errors++; $display("FAIL raw%0d_ready i=%0d: got %b want 1", nf, i, rdy); end
                sb_q.push_back('{dst: 2'(i + 1), due: cyc + ST + ((i == 1) ? n_stall_exp : 0)});
            end
            exp_st = (i >= 2) && (i < 2 + n_stall_exp);
            exp_f1 = !nf && (i == 4);
            n_checks++; if (st !== exp_st) begin n_errors++; $display("FAIL raw%0d_stall i=%0d: got %b want %b", nf, i, st, exp_st); end
            n_checks++; if ({f1, f2} !== {exp_f1, 1'b0}) begin n_errors++; $display("FAIL raw%0d_fwd i=%0d: got %b want %b", nf, i, {f1, f2}, {exp_f1, 1'b0}); end
            if (rw) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL raw%0d_wb cyc=%0d: got write r%0d want none", nf, cyc, wa);
                end else begin
                    e = sb_q.pop_front();
                    if (wa !== e.dst || cyc != e.due) begin
                        n_errors++; $display("FAIL raw%0d_wb: got r%0d at %0d want r%0d at %0d", nf, wa, cyc, e.dst, e.due);
                    end
                end
            end
        end
        scnt = nf ? n_stall_cnt : a_stall_cnt;
        n_checks++; if (scnt !== 16'(n_stall_exp)) begin n_errors++; $display("FAIL raw%0d_stall_cnt: got %0d want %0d", nf, scnt, n_stall_exp); end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL raw%0d_pending: got %0d missing want 0", nf, sb_q.size()); end
    endtask

    // Mid-stage match outranks a writeback match; then a source-2 bypass.
    task automatic test_fwd_priority();
        logic [11:0] exp_st = 12'h018;
        logic [11:0] exp_f1 = 12'h020;
        logic [11:0] exp_f2 = 12'h400;
        wb_t         e;
        do_reset();
        count_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            case (i)
                0:       offer(1'b1, 8'h61, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
                1:       offer(1'b1, 8'h62, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
                2:       offer(1'b1, 8'h63, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd3);
                6:       offer(1'b1, 8'h64, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
                9:       offer(1'b1, 8'h65, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 2'd3);
                default: idle();
            endcase
            #1;
            if (i == 0 || i == 1 || i == 6) sb_q.push_back('{dst: fetch_dst, due: cyc + ST});
            n_checks++; if (a_stall !== exp_st[i]) begin n_errors++; $display("FAIL prio_stall i=%0d: got %b want %b", i, a_stall, exp_st[i]); end
            n_checks++; if ({a_fwd1, a_fwd2} !== {exp_f1[i], exp_f2[i]}) begin n_errors++; $display("FAIL prio_fwd i=%0d: got %b want %b", i, {a_fwd1, a_fwd2}, {exp_f1[i], exp_f2[i]}); end
            if (a_rf_write) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL prio_wb cyc=%0d: got write r%0d want none", cyc, a_waddr);
                end else begin
                    e = sb_q.pop_front();
                    if (a_waddr !== e.dst || cyc != e.due) begin
                        n_errors++; $display("FAIL prio_wb: got r%0d at %0d want r%0d at %0d", a_waddr, cyc, e.dst, e.due);
                    end
                end
            end
        end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL prio_pending: got %0d missing want 0", sb_q.size()); end
    endtask

    // Full pipe I1..I4, flush with I5 offered: stages 1-2 squash (I4, I3 leave
    // stages 1 and 2; I3 moves into stage 3 which advances normally).
    task automatic test_flush();
        wb_t e;
        do_reset();
        count_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            flush = (i == 4);
            if (i < 5) offer(1'b1, 8'(8'h11 * (i + 1)), 1'b1, 2'(i), 1'b0, 2'd0, 1'b0, 2'd0);
            else       idle();
            #1;
            if (i < 3) sb_q.push_back('{dst: 2'(i), due: cyc + ST});
            if (i == 4) begin
                n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", a_ready); end
            end
            if (i == 5) begin
                n_checks++; if (a_valid !== 4'b1100) begin n_errors++; $display("FAIL flush_valid: got %b want 1100", a_valid); end
                n_checks++; if (a_instr !== {8'h22, 8'h33, NOP, NOP}) begin n_errors++; $display("FAIL flush_instr: got %h want %h", a_instr, {8'h22, 8'h33, NOP, NOP}); end
            end
            if (a_rf_write) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL flush_wb cyc=%0d: got write r%0d want none", cyc, a_waddr);
                end else begin
                    e = sb_q.pop_front();
                    if (a_waddr !== e.dst || cyc != e.due) begin
                        n_errors++; $display("FAIL flush_wb: got r%0d at %0d want r%0d at %0d", a_waddr, cyc, e.dst, e.due);
                    end
                end
            end
        end
        n_checks++; if (a_flush_cnt !== 16'd1) begin n_errors++; $display("FAIL flush_cnt: got %0d want 1", a_flush_cnt); end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL flush_pending: got %0d missing want 0", sb_q.size()); end
    endtask

    task automatic test_flush_stall();
        wb_t e;
        do_reset();
        count_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            flush = (i == 3);
            if (i == 0)      offer(1'b1, 8'h71, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
            else if (i == 1) offer(1'b1, 8'h72, 1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0);
            else             idle();
            #1;
            if (i == 0) sb_q.push_back('{dst: 2'd1, due: cyc + ST});
            if (i == 2 || i == 3) begin
                n_checks++; if (a_stall !== 1'b1) begin n_errors++; $display("FAIL fs_stall i=%0d: got %b want 1", i, a_stall); end
            end
            if (i == 3) begin
                n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL fs_ready: got %b want 0", a_ready); end
            end
            if (i == 4) begin
                n_checks++; if (a_valid !== 4'b1000) begin n_errors++; $display("FAIL fs_valid: got %b want 1000", a_valid); end
                n_checks++; if (a_instr[7:0] !== NOP) begin n_errors++; $display("FAIL fs_stage1: got %h want %h", a_instr[7:0], NOP); end
            end
            if (a_rf_write) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++; $display("FAIL fs_wb cyc=%0d: got write r%0d want none", cyc, a_waddr);
                end else begin
                    e = sb_q.pop_front();
                    if (a_waddr !== e.dst || cyc != e.due) begin
                        n_errors++; $display("FAIL fs_wb: got r%0d at %0d want r%0d at %0d", a_waddr, cyc, e.dst, e.due);
                    end
                end
            end
        end
        n_checks++; if (a_stall_cnt !== 16'd1) begin n_errors++; $display("FAIL fs_stall_cnt: got %0d want 1", a_stall_cnt); end
        n_checks++; if (a_flush_cnt !== 16'd1) begin n_errors++; $display("FAIL fs_flush_cnt: got %0d want 1", a_flush_cnt); end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL fs_pending: got %0d missing want 0", sb_q.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        count_en = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            if (i == 15 || i == 19) begin
                n_checks++; if (c_cyc_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_cycle i=%0d: got %0d want 15", i, c_cyc_cnt); end
                n_checks++; if (c_flush_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_flush i=%0d: got %0d want 15", i, c_flush_cnt); end
            end
        end
        n_checks++; if ({c_stall_cnt, c_retire_cnt} !== 8'd0) begin n_errors++; $display("FAIL sat_idle_cnts: got %h want 00", {c_stall_cnt, c_retire_cnt}); end
        @(negedge clock);
        flush = 1'b0;
        count_clr = 1'b1;
        @(posedge clock);
        #1;
        count_clr = 1'b0;
        n_checks++; if ({c_cyc_cnt, c_flush_cnt} !== 8'd0) begin n_errors++; $display("FAIL sat_clr: got %h want 00", {c_cyc_cnt, c_flush_cnt}); end
    endtask

    task automatic test_reset_midstream();
        count_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            reset = (i == 4);
            if (i < 4) offer(1'b1, 8'(8'h81 + i), 1'b1, 2'(i), 1'b0, 2'd0, 1'b0, 2'd0);
            else       idle();
            #1;
            if (i == 4) begin
                n_checks++; if (c_rf_write !== 1'b1) begin n_errors++; $display("FAIL rst_mid_wb_before: got %b want 1", c_rf_write); end
            end
        end
        n_checks++; if ({c_valid, c_rf_write} !== 5'b0) begin n_errors++; $display("FAIL rst_mid_state: got %b want 00000", {c_valid, c_rf_write}); end
        n_checks++; if (c_instr !== {4{NOP}}) begin n_errors++; $display("FAIL rst_mid_instr: got %h want %h", c_instr, {4{NOP}}); end
        n_checks++; if ({c_cyc_cnt, c_stall_cnt, c_flush_cnt, c_retire_cnt} !== 16'd0) begin n_errors++; $display("FAIL rst_mid_cnts: got %h want 0000", {c_cyc_cnt, c_stall_cnt, c_flush_cnt, c_retire_cnt}); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw(1'b0);
        test_raw(1'b1);
        test_fwd_priority();
        test_flush();
        test_flush_stall();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and sequencing controller for the multicycle processor family: it owns the in-flight instruction chain (decode through writeback), detects read-after-write hazards, selects writeback forwarding or inserts stall bubbles, squashes younger stages on a taken branch, and keeps saturating performance counters. It sits between instruction fetch (memory `q_pc` port) and the per-stage decode logic. It replaces fixed four-stage IR chains and NOP-insertion muxes with one block generalised in depth, width and forwarding mode.

## Interface
- `IW`, 8: instruction width.
- `RW`, 2: register-address width.
- `STAGES`, 4: pipeline depth after fetch (≥3). Stage 1 is decode/RF-read; stage `STAGES` is writeback.
- `BR_STAGE`, 3: stage where a taken branch is resolved (2..`STAGES`).
- `FWD`, 1: 1 enables writeback→decode bypass; 0 means stall-only.
- `CW`, 16: performance counter width.
- `NOP`, 8'b00001010: bubble encoding (`IW` bits).

Ports:
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `fetch_valid` in 1: `fetch_instr` is valid this cycle.
- `fetch_instr` in `IW`: fetched instruction.
- `fetch_wr` in 1: the instruction writes a register.
- `fetch_dst` in `RW`: destination register.
- `fetch_use1`, `fetch_use2` in 1: source 1 / source 2 is read.
- `fetch_src1`, `fetch_src2` in `RW`: source registers.
- `fetch_ready` out 1: the instruction is accepted on this edge.
- `flush` in 1: branch taken, resolved in stage `BR_STAGE` this cycle.
- `count_en` in 1: counters advance.
- `count_clr` in 1: counters clear.
- `stage_instr` out `STAGES*IW`: stage k occupies bits [k*IW-1:(k-1)*IW].
- `stage_valid` out `STAGES`: per-stage valid.
- `stall` out 1: decode is held this cycle.
- `fwd_sel1`, `fwd_sel2` out 1: source 1 / source 2 takes writeback data instead of RF data.
- `rf_write` out 1: writeback is active this cycle.
- `rf_waddr` out `RW`: writeback destination register.
- `cycle_cnt`, `stall_cnt`, `flush_cnt`, `retire_cnt` out `CW`: performance counters.

## Operation
- **Stage contents.** Each stage k holds {valid, instr, wr, dst, use1/2, src1/2}. A bubble is valid=0, instr=`NOP`, wr=0, use=0.
- **Hazard on a used source s in valid stage 1.** A hazard exists when a stage j has valid, wr=1 and dst==s.
  - If the match is in j∈[2, `STAGES`-1], `stall`=1.
  - If the match is in j=`STAGES`: with `FWD`=1, `fwd_sel`=1 and no stall; with `FWD`=0, `stall`=1.
  - Multiple matches: stall takes priority over forward.
- **Normal advance.** Stage k+1←k for all k. Stage 1←fetch entry if `fetch_valid`, otherwise a bubble.
- **Stall.** Stage 1 holds its contents. A bubble enters stage 2. Stages 3..`STAGES` advance.
- **Flush.** Stages 1..`BR_STAGE`-1 become bubbles at the edge and the fetch input is dropped. Stages ≥`BR_STAGE` advance normally.
- **Flush with stall in the same cycle.** Flush wins: no hold, and stall is not counted.
- **Handshake.** `fetch_ready` = ~`stall` & ~`flush`. `fetch_valid` is ignored while `fetch_ready`=0; the source must hold the instruction.
- **Writeback.** `rf_write` = valid & wr of stage `STAGES`. `rf_waddr` = dst of stage `STAGES`.
- **Counters.** When `count_en`=1:
  - `cycle_cnt` +1 every cycle.
  - `stall_cnt` +1 when `stall` & ~`flush`.
  - `flush_cnt` +1 when `flush`.
  - `retire_cnt` +1 when stage `STAGES` is valid.
  - All counters saturate at all-ones.
  - `count_clr` zeroes all counters and has priority over increment.

## Timing
- **Reset values.** All stages are bubbles and `stage_valid`=0. `stall`, `fwd_sel1/2`, `rf_write`=0. `rf_waddr`=0. All counters=0. `fetch_ready`=1 in the first cycle after reset unless `flush` is asserted.
- **Reset mid-operation.** All in-flight instructions are discarded at the next edge, including any writeback pending that cycle. `rf_write` is driven from registered state, so it is 0 only from the cycle after the reset edge.
- **Combinational outputs.** `stall`, `fwd_sel*`, `fetch_ready` and `rf_*` are combinational from current state and inputs; they are valid within the same cycle.
- **Latency.** An instruction accepted at edge t is in stage 1 during cycle t+1 and in stage `STAGES` during cycle t+`STAGES` with no stalls. Each stall cycle adds 1.
- **RF ordering.** The RF write occurs at the edge ending the writeback cycle. A same-cycle decode read therefore needs forwarding.

## Test plan
- **Independent writes.** Defaults, reset, then three instructions writing r1, r2, r3 with no source use, back-to-back. Required: `rf_write` on cycles 4, 5, 6 after acceptance with `rf_waddr`=1, 2, 3; `stall` never asserted; `retire_cnt`=3.
- **RAW with forwarding.** A writes r1, B reads r1 on the next fetch, `FWD`=1. Required: `stall`=1 for 2 cycles (A in stages 2, 3); then `fwd_sel1`=1 for one cycle with A in stage 4; `stall_cnt`=2.
- **RAW without forwarding.** Same stimulus with `FWD`=0. Required: 3 stall cycles, `fwd_sel1` never asserted, `stall_cnt`=3.
- **Flush.** Pipeline full, `flush` pulsed for 1 cycle. Required: stages 1–2 become `NOP` with valid=0, the offered fetch is not accepted (`fetch_ready`=0), stages 3→4 advance, `flush_cnt`=1.
- **Flush with stall.** `flush` asserted during an active RAW stall. Required: flush takes effect, `stall_cnt` unchanged, the stalled instruction is squashed.
- **Counter saturation and reset.** `CW`=4, `count_en`=1 for 20 cycles. Required: `cycle_cnt`=15 and held; `count_clr`→0 at the next edge. Then assert `reset` mid-stream. Required: `stage_valid`=0 and `rf_write`=0 from the next cycle, all counters=0.
